bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It takes an unsigned binary value, such as a candidate or result from the prime datapath, and produces DIGITS packed BCD nibbles. Each nibble drives one downstream 4-bit to 7-segment decoder instance on the board display. A start/busy/done handshake controls it, and each conversion takes one iteration per input bit.

Parameters:
IN_WIDTH, 14, width of binary input; conversion takes IN_WIDTH shift iterations
DIGITS, 4, number of BCD output digits; MAX_VAL = 10^DIGITS - 1 (derived localparam, 9999 at defaults)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request conversion of binIn; sampled only when not busy
binIn  input  IN_WIDTH  unsigned binary value, latched on accepted start
busy  output  1  high while a conversion is in progress (SHIFT state)
done  output  1  single-cycle pulse: bcdOut/overflow updated this cycle
bcdOut  output  4*DIGITS  packed BCD; [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands
overflow  output  1  last converted value exceeded MAX_VAL; held with bcdOut

Behaviour:
- Reset (synchronous, highest priority, also mid-conversion): state=IDLE; busy=0, done=0, overflow=0, bcdOut=0; scratch and counter cleared; the in-flight conversion is discarded.
- States: IDLE, SHIFT, DONE. busy=1 only in SHIFT. done=1 only in DONE.
- IDLE or DONE, start=1 at edge E0:
  - latch binIn into the shift register and clear the BCD scratch;
  - iteration counter = IN_WIDTH;
  - ovfPending = (binIn > MAX_VAL);
  - state goes to SHIFT.
- DONE with start=0: state goes to IDLE. Back-to-back conversions are allowed, since start is accepted in the DONE cycle.
- SHIFT, each edge:
  - every scratch nibble >= 5 gets +3 (no carry between nibbles);
  - then {scratch, shiftReg} shifts left one bit, with the binary MSB entering scratch bit 0;
  - counter decrements.
- On the edge where counter goes 1 to 0 (edge E0+IN_WIDTH):
  - bcdOut = final scratch, or all nibbles 4'h9 if ovfPending;
  - overflow = ovfPending;
  - state goes to DONE, so done is high for exactly one cycle.
- Latency: done is visible IN_WIDTH edges after the start edge (14 at defaults). busy is high for IN_WIDTH cycles.
- start while in SHIFT is ignored; no queueing; binIn changes during SHIFT have no effect.
- bcdOut and overflow hold their last values between done pulses; they never show partial results.
- Scratch width is 4*DIGITS. Bits shifted beyond the scratch are dropped; this only matters when overflow is set, because then the output saturates.
- Every bcdOut nibble is always in 0..9. Values A..F never reach the decoder.
- No combinational path from start or binIn to any output.

Test Plan:
- Reset, then start with binIn=0 -> busy high 14 cycles; done pulse at start edge +14; bcdOut=16'h0000, overflow=0.
- binIn=4791 -> after 14 cycles bcdOut=16'h4791 (digits 4,7,9,1), overflow=0, done high exactly 1 cycle.
- binIn=9999 -> bcdOut=16'h9999, overflow=0. Then binIn=10000 -> bcdOut=16'h9999, overflow=1. Then binIn=16383 -> bcdOut=16'h9999, overflow=1.
- Start with binIn=1234, then start=1 with binIn=5678 on cycles 3..8 of busy -> second request ignored; result 16'h1234; busy stays 14 cycles.
- Start binIn=321; assert start with binIn=65 during the done cycle -> done for 16'h0321, busy rises next cycle; after 14 more edges bcdOut=16'h0065.
- Convert 42 (bcdOut=16'h0042), start 8888, assert reset on cycle 7 -> next cycle busy=0, done=0, bcdOut=0, overflow=0. A fresh start binIn=8888 then yields 16'h8888.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Sequential shift-and-add-3 binary-to-BCD converter with
//                start/busy/done handshake and saturating overflow output.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int IN_WIDTH = 14,
    parameter int DIGITS   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   binIn,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcdOut,
    output logic                  overflow
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = $clog2(IN_WIDTH + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned acc;
        acc = 64'd1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 64'd10;
        end
        return acc;
    endfunction

    localparam longint unsigned c_MAX_VAL = pow10(DIGITS) - 64'd1;

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_SHIFT = 2'd1,
        c_DONE  = 2'd2
    } stateT;

    stateT                 r_state;
    logic [IN_WIDTH-1:0]   r_shiftReg;
    logic [c_BCD_W-1:0]    r_scratch;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_ovfPending;
    logic                  r_busy;
    logic                  r_done;
    logic [c_BCD_W-1:0]    r_bcdOut;
    logic                  r_overflow;

    logic [c_BCD_W-1:0]    w_adj;
    logic [c_BCD_W-1:0]    w_nextScratch;
    logic                  w_inRange;

    // Each nibble is corrected independently; no carry crosses nibble borders.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign w_adj[4*d +: 4] = (r_scratch[4*d +: 4] >= 4'd5) ?
                                 (r_scratch[4*d +: 4] + 4'd3) :
                                 r_scratch[4*d +: 4];
    end

    assign w_nextScratch = {w_adj[c_BCD_W-2:0], r_shiftReg[IN_WIDTH-1]};
    assign w_inRange     = (64'(binIn) <= c_MAX_VAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_shiftReg   <= '0;
            r_scratch    <= '0;
            r_count      <= '0;
            r_ovfPending <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bcdOut     <= '0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_shiftReg   <= binIn;
                        r_scratch    <= '0;
                        r_count      <= c_CNT_W'(IN_WIDTH);
                        r_ovfPending <= ~w_inRange;
                        r_busy       <= 1'b1;
                        r_state      <= c_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                c_SHIFT: begin
                    r_scratch  <= w_nextScratch;
                    r_shiftReg <= {r_shiftReg[IN_WIDTH-2:0], 1'b0};
                    r_count    <= r_count - c_CNT_W'(1);
                    if (r_count == c_CNT_W'(1)) begin
                        // Out-of-range inputs saturate so the display never shows truncated digits.
                        r_bcdOut   <= r_ovfPending ? {DIGITS{4'h9}} : w_nextScratch;
                        r_overflow <= r_ovfPending;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= c_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcdOut   = r_bcdOut;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_bcd_seq
//  Description : Randomised and directed self-checking bench for bin_to_bcd_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    localparam int IN_WIDTH = 14;
    localparam int DIGITS   = 4;
    localparam int LATENCY  = IN_WIDTH;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [IN_WIDTH-1:0]  binIn;
    logic                 busy;
    logic                 done;
    logic [4*DIGITS-1:0]  bcdOut;
    logic                 overflow;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .binIn    (binIn),
        .busy     (busy),
        .done     (done),
        .bcdOut   (bcdOut),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits by division, saturated to 9999 above the range.
    function automatic logic [15:0] refBcd(input int val);
        int v;
        logic [15:0] r;
        if (val > 9999) return 16'h9999;
        v = val;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Drive start for one cycle; returns at the negedge right after the accepting edge.
    task automatic pulseStart(input int val);
        start = 1'b1;
        binIn = IN_WIDTH'(val);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy samples until done is seen, bounded so a stuck DUT still ends.
    task automatic waitDone(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            if (busy) lat++;
            @(negedge clk);
        end
        checkVal("doneSeen", done, 1);
    endtask

    task automatic convertCheck(input string tag, input int val);
        int lat;
        pulseStart(val);
        waitDone(lat);
        checkVal({tag, "_lat"}, lat, LATENCY);
        checkVal({tag, "_bcd"}, bcdOut, refBcd(val));
        checkVal({tag, "_ovf"}, overflow, (val > 9999) ? 1 : 0);
        @(negedge clk);
        checkVal({tag, "_donePulse"}, done, 0);
    endtask

    initial begin
        int lat;
        int cyc;
        int v;
        int directed[5] = '{0, 4791, 9999, 10000, 16383};

        reset = 1'b1;
        start = 1'b0;
        binIn = '0;
        repeat (3) @(negedge clk);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_done", done, 0);
        checkVal("rst_bcd", bcdOut, 0);
        checkVal("rst_ovf", overflow, 0);
        reset = 1'b0;
        @(negedge clk);

        foreach (directed[i]) convertCheck($sformatf("dir%0d", directed[i]), directed[i]);

        // Outputs must hold between conversions.
        repeat (3) @(negedge clk);
        checkVal("hold_bcd", bcdOut, 16'h9999);
        checkVal("hold_ovf", overflow, 1);

        for (int n = 0; n < 25; n++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383))
                                            : int'($urandom_range(0, 9999));
            convertCheck($sformatf("rnd%0d", v), v);
        end

        // Start requests during busy are ignored.
        pulseStart(1234);
        lat = 0;
        cyc = 0;
        while (!done && cyc < 40) begin
            cyc++;
            if (busy) lat++;
            start = (cyc >= 3 && cyc <= 8);
            binIn = IN_WIDTH'(start ? 5678 : 1234);
            @(negedge clk);
        end
        start = 1'b0;
        checkVal("ign_doneSeen", done, 1);
        checkVal("ign_lat", lat, LATENCY);
        checkVal("ign_bcd", bcdOut, refBcd(1234));
        @(negedge clk);
        checkVal("ign_idle", busy, 0);

        // Back-to-back: start accepted in the done cycle.
        pulseStart(321);
        waitDone(lat);
        checkVal("b2b1_bcd", bcdOut, refBcd(321));
        start = 1'b1;
        binIn = IN_WIDTH'(65);
        @(negedge clk);
        start = 1'b0;
        checkVal("b2b_busyRise", busy, 1);
        waitDone(lat);
        checkVal("b2b2_lat", lat, LATENCY);
        checkVal("b2b2_bcd", bcdOut, refBcd(65));
        checkVal("b2b2_ovf", overflow, 0);
        @(negedge clk);

        // Reset mid-conversion discards everything.
        convertCheck("pre42", 42);
        pulseStart(8888);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkVal("mid_busy", busy, 0);
        checkVal("mid_done", done, 0);
        checkVal("mid_bcd", bcdOut, 0);
        checkVal("mid_ovf", overflow, 0);
        @(negedge clk);
        convertCheck("post8888", 8888);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
